// File: rtl/slot_spinner.sv
// slot_spinner: three-reel slot machine FSM with staggered reel stops and win detection
module slot_spinner #(
  parameter int SPIN_DIV = 4,
  parameter int STOP_GAP = 8,
  parameter int MAX_SYM  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin_btn,
  input  logic       stop_btn,
  output logic [3:0] slot1_num,
  output logic [3:0] slot2_num,
  output logic [3:0] slot3_num,
  output logic       busy,
  output logic       done,
  output logic       jackpot,
  output logic       pair
);
  localparam int PW = SPIN_DIV > 1 ? $clog2(SPIN_DIV) : 1;
  localparam int GW = STOP_GAP > 1 ? $clog2(STOP_GAP) : 1;
  typedef enum logic [2:0] {IDLE, SPIN, STOP1, STOP2, RESULT} state_t;
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [GW-1:0] gap;
  logic par, spin_prev, stop_prev, spin_arm, stop_arm;
  logic spin_edge, stop_edge, spinning, tick, gap_end, run1, run2, run3, eq12, eq23, eq13;
  function automatic logic [3:0] up(input logic [3:0] v);
    return v == 4'(MAX_SYM) ? 4'd0 : v + 4'd1;
  endfunction
  function automatic logic [3:0] dn(input logic [3:0] v);
    return v == 4'd0 ? 4'(MAX_SYM) : v - 4'd1;
  endfunction
  // arm bits block an edge from a button that was already high when reset released
  assign spin_edge = spin_btn & ~spin_prev & spin_arm;
  assign stop_edge = stop_btn & ~stop_prev & stop_arm;
  assign spinning  = state inside {SPIN, STOP1, STOP2};
  assign tick      = spinning && presc == PW'(SPIN_DIV - 1);
  assign gap_end   = gap == GW'(STOP_GAP - 1);
  assign run1      = tick && state == SPIN && !stop_edge;
  assign run2      = tick && (state == SPIN || (state == STOP1 && !gap_end));
  assign run3      = tick && (state inside {SPIN, STOP1} || (state == STOP2 && !gap_end));
  assign eq12      = slot1_num == slot2_num;
  assign eq23      = slot2_num == slot3_num;
  assign eq13      = slot1_num == slot3_num;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = spin_edge ? SPIN : IDLE;
      SPIN:    state_nx = stop_edge ? STOP1 : SPIN;
      STOP1:   state_nx = gap_end ? STOP2 : STOP1;
      STOP2:   state_nx = gap_end ? RESULT : STOP2;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      gap       <= '0;
      par       <= 1'b0;
      spin_prev <= 1'b0;
      stop_prev <= 1'b0;
      spin_arm  <= 1'b0;
      stop_arm  <= 1'b0;
      slot1_num <= 4'd0;
      slot2_num <= 4'd0;
      slot3_num <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      jackpot   <= 1'b0;
      pair      <= 1'b0;
    end else begin
      state     <= state_nx;
      spin_prev <= spin_btn;
      stop_prev <= stop_btn;
      spin_arm  <= spin_arm | ~spin_btn;
      stop_arm  <= stop_arm | ~stop_btn;
      busy      <= state_nx != IDLE;
      done      <= state_nx == RESULT;
      if (state == IDLE && spin_edge) begin
        presc   <= '0;
        gap     <= '0;
        par     <= 1'b0;
        jackpot <= 1'b0;
        pair    <= 1'b0;
      end else if (spinning) begin
        presc <= tick ? '0 : presc + 1'b1;
        par   <= par ^ tick;
        gap   <= (state == SPIN || gap_end) ? '0 : gap + 1'b1;
      end
      if (run1) slot1_num <= up(slot1_num);
      if (run2) slot2_num <= dn(slot2_num);
      if (run3 && par) slot3_num <= up(slot3_num);
      // reel3 is frozen at this edge, so the current values are final
      if (state == STOP2 && gap_end) begin
        jackpot <= eq12 & eq23;
        pair    <= (eq12 | eq23 | eq13) & ~(eq12 & eq23);
      end
    end
  end
endmodule

// File: doc/slot_spinner.md
SLOT_SPINNER -- requirements
Module: slot_spinner

Interface
REQ-001 The block SHALL have parameter SPIN_DIV, default 4, giving the clock cycles per reel step (minimum 1).
REQ-002 The block SHALL have parameter STOP_GAP, default 8, giving the cycles between successive reel stops (minimum 1).
REQ-003 The block SHALL have parameter MAX_SYM, default 9, giving the largest reel symbol (≤15).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port spin_btn, input, 1 bit: start request, synchronous level; only its rising edge is used.
REQ-007 The block SHALL have port stop_btn, input, 1 bit: stop request, synchronous level; only its rising edge is used.
REQ-008 The block SHALL have ports slot1_num, slot2_num, slot3_num, each output, 4 bits: reel values that feed display_encoder.
REQ-009 The block SHALL have port busy, output, 1 bit: high from spin start until the result is published.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when all reels have stopped.
REQ-011 The block SHALL have port jackpot, output, 1 bit: all three reels are equal.
REQ-012 The block SHALL have port pair, output, 1 bit: exactly two of the three reels are equal.

Function
REQ-013 Edge detect: the block SHALL register each button's previous value; an edge is current=1 and previous=0, and it acts at the next clock edge.
REQ-014 The FSM SHALL have states IDLE, SPIN, STOP1, STOP2, RESULT.
REQ-015 IDLE->SPIN SHALL occur on a spin edge; on this transition the prescaler, gap counter and tick parity clear to 0, and jackpot and pair clear to 0.
REQ-016 In SPIN, the prescaler SHALL count 0..SPIN_DIV-1 and wrap; a tick occurs in each cycle where it equals SPIN_DIV-1.
REQ-017 On each tick, a spinning reel1 SHALL go +1, with MAX_SYM wrapping to 0.
REQ-018 On each tick, a spinning reel2 SHALL go -1, with 0 wrapping to MAX_SYM.
REQ-019 A spinning reel3 SHALL go +1 (with wrap) on every second tick only, using the tick parity bit.
REQ-020 SPIN->STOP1 SHALL occur on a stop edge: reel1 freezes at its current value and the gap counter clears.
REQ-021 In STOP1 and STOP2, the prescaler and ticks SHALL continue for the reels that are still spinning.
REQ-022 In STOP1 and STOP2, the gap counter SHALL count 0..STOP_GAP-1.
REQ-023 At STOP_GAP-1 in STOP1, the block SHALL freeze reel2 and go to STOP2.
REQ-024 At STOP_GAP-1 in STOP2, the block SHALL freeze reel3 and go to RESULT.
REQ-025 A reel freezes with the value it holds at the freezing edge; a coincident tick SHALL NOT apply to a freezing reel.
REQ-026 RESULT SHALL last exactly one cycle: done=1, jackpot and pair are registered from the frozen values, then the FSM returns to IDLE.
REQ-027 busy SHALL be 1 in SPIN, STOP1, STOP2 and RESULT, and 0 in IDLE.
REQ-028 Reel values, jackpot and pair SHALL hold in IDLE until the next spin edge; reels resume from their held values.
REQ-029 Spin edges outside IDLE SHALL be ignored.
REQ-030 Stop edges outside SPIN SHALL be ignored.
REQ-031 A spin edge and a stop edge in the same cycle in IDLE: spin SHALL win and stop SHALL be discarded.
REQ-032 jackpot and pair SHALL never both be 1.
REQ-033 All outputs SHALL be registered, with no combinational path from the buttons to the outputs.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to IDLE and all reels, counters, the parity bit, the previous-button registers, busy, done, jackpot and pair SHALL go to 0, overriding all other activity including mid-spin.
REQ-035 A button held high through reset release SHALL NOT produce an edge until it has been seen low.

Verification
REQ-036 rst pulse mid-STOP1 -> next cycle: state IDLE, slot1..3=0, busy=0, done=0, jackpot=0, pair=0.
REQ-037 SPIN_DIV=2, from reset, spin edge, no stop -> 8 cycles after entering SPIN: slot1=4, slot2=6, slot3=2, busy=1.
REQ-038 SPIN_DIV=16, STOP_GAP=3, spin edge, then stop edge on the first SPIN cycle -> no ticks occur; reel2 freezes 3 cycles and reel3 6 cycles after the stop; done pulses once; result 0,0,0, jackpot=1, pair=0, busy=0 the cycle after done.
REQ-039 SPIN_DIV=1, STOP_GAP=2, spin edge, stop edge after 3 ticks -> slot1=3 frozen, slot2 and slot3 continue for 2 and 4 further cycles; check final values against a reference model and that pair/jackpot are consistent.
REQ-040 Extra spin edges during STOP2, and a stop edge in IDLE -> no state change and no extra done pulse.
REQ-041 spin_btn held high across rst release, then a spin edge the same cycle as a stop edge in IDLE -> no start until spin_btn has been seen low; the simultaneous edges give SPIN with all reels spinning (stop discarded).
